// File: rtl/mips_pkg.sv
// Shared constants for the multicycle MIPS control slice.
// ALU ops, opcode/funct codes, FSM states and the control bundle.
package mips_pkg;

  localparam logic [2:0] ALU_AND = 3'b000;
  localparam logic [2:0] ALU_OR  = 3'b001;
  localparam logic [2:0] ALU_ADD = 3'b010;
  localparam logic [2:0] ALU_SUB = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b100;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_J     = 6'h02;
  localparam logic [5:0] OP_BEQ   = 6'h04;
  localparam logic [5:0] OP_ADDI  = 6'h08;
  localparam logic [5:0] OP_LW    = 6'h23;
  localparam logic [5:0] OP_SW    = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  typedef enum logic [3:0] {
    S_FETCH     = 4'd0,
    S_DECODE    = 4'd1,
    S_MEM_ADDR  = 4'd2,
    S_MEM_READ  = 4'd3,
    S_MEM_WB    = 4'd4,
    S_MEM_WRITE = 4'd5,
    S_R_EXEC    = 4'd6,
    S_R_WB      = 4'd7,
    S_BRANCH    = 4'd8,
    S_JUMP      = 4'd9,
    S_ADDI_EXEC = 4'd10,
    S_ADDI_WB   = 4'd11,
    S_ILLEGAL   = 4'd12
  } state_e;

  typedef struct packed {
    logic [2:0] alu_op;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       iord;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       pc_write;
    logic       pc_write_cond;
    logic [1:0] pc_source;
    logic       reg_write;
    logic       reg_dst;
    logic       mem_to_reg;
    logic       instr_done;
  } ctrl_t;

endpackage

// File: rtl/mips_alu_decode.sv
// R-type funct to ALU op decoder.
// Ports: funct in; alu_op out; funct_ok high for supported functs.
module mips_alu_decode
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [2:0] alu_op,
  output logic       funct_ok
);

  always_comb begin
    alu_op   = ALU_ADD;
    funct_ok = 1'b1;
    unique case (funct)
      FN_ADD:  alu_op = ALU_ADD;
      FN_SUB:  alu_op = ALU_SUB;
      FN_AND:  alu_op = ALU_AND;
      FN_OR:   alu_op = ALU_OR;
      FN_SLT:  alu_op = ALU_SLT;
      default: funct_ok = 1'b0;
    endcase
  end

endmodule

// File: rtl/mips_mc_control.sv
// Multicycle MIPS main control FSM (clk, rst_n, opcode, funct, mem_ready in;
// datapath controls, instr_done, illegal, state out). MIPS_MC_PERF_CNT_EN adds counters.
module mips_mc_control
  import mips_pkg::*;
#(
  parameter int OP_WIDTH    = 3,
  parameter int STATE_WIDTH = 4
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [5:0]             opcode,
  input  logic [5:0]             funct,
  input  logic                   mem_ready,
  output logic [OP_WIDTH-1:0]    alu_op,
  output logic                   alu_src_a,
  output logic [1:0]             alu_src_b,
  output logic                   iord,
  output logic                   mem_read,
  output logic                   mem_write,
  output logic                   ir_write,
  output logic                   pc_write,
  output logic                   pc_write_cond,
  output logic [1:0]             pc_source,
  output logic                   reg_write,
  output logic                   reg_dst,
  output logic                   mem_to_reg,
  output logic                   instr_done,
  output logic                   illegal,
`ifdef MIPS_MC_PERF_CNT_EN
  output logic [31:0]            cycle_count,
  output logic [31:0]            instr_count,
`endif
  output logic [STATE_WIDTH-1:0] state
);

  state_e     cur;
  state_e     nxt;
  ctrl_t      c;
  logic [2:0] r_op;
  logic       fn_ok;
  logic       ill_q;

  mips_alu_decode u_alu_dec (
    .funct    (funct),
    .alu_op   (r_op),
    .funct_ok (fn_ok)
  );

  always_comb begin
    nxt = cur;
    unique case (cur)
      S_FETCH:     if (mem_ready) nxt = S_DECODE;
      S_DECODE: begin
        unique case (opcode)
          OP_RTYPE:     nxt = S_R_EXEC;
          OP_LW, OP_SW: nxt = S_MEM_ADDR;
          OP_BEQ:       nxt = S_BRANCH;
          OP_J:         nxt = S_JUMP;
          OP_ADDI:      nxt = S_ADDI_EXEC;
          default:      nxt = S_ILLEGAL;
        endcase
      end
      S_MEM_ADDR:  nxt = (opcode == OP_SW) ? S_MEM_WRITE : S_MEM_READ;
      S_MEM_READ:  if (mem_ready) nxt = S_MEM_WB;
      S_MEM_WRITE: if (mem_ready) nxt = S_FETCH;
      S_R_EXEC:    nxt = fn_ok ? S_R_WB : S_ILLEGAL;
      S_ADDI_EXEC: nxt = S_ADDI_WB;
      S_MEM_WB, S_R_WB, S_BRANCH, S_JUMP, S_ADDI_WB:
                   nxt = S_FETCH;
      S_ILLEGAL:   nxt = S_ILLEGAL;
      default:     nxt = S_ILLEGAL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cur   <= S_FETCH;
      ill_q <= 1'b0;
    end else begin
      cur <= nxt;
      if (nxt == S_ILLEGAL) ill_q <= 1'b1;
    end
  end

  // Moore decode; rst_n gates everything so a held reset issues nothing.
  always_comb begin
    c        = '0;
    c.alu_op = ALU_ADD;
    if (rst_n) begin
      unique case (cur)
        S_FETCH: begin
          c.mem_read  = 1'b1;
          c.alu_src_b = SRCB_FOUR;
          c.pc_source = PCSRC_ALU;
          c.ir_write  = mem_ready;
          c.pc_write  = mem_ready;
        end
        S_DECODE:    c.alu_src_b = SRCB_IMM_SH;
        S_MEM_ADDR, S_ADDI_EXEC: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_IMM;
        end
        S_MEM_READ: begin
          c.mem_read = 1'b1;
          c.iord     = 1'b1;
        end
        S_MEM_WB: begin
          c.reg_write  = 1'b1;
          c.mem_to_reg = 1'b1;
          c.instr_done = 1'b1;
        end
        S_MEM_WRITE: begin
          c.mem_write  = 1'b1;
          c.iord       = 1'b1;
          c.instr_done = mem_ready;
        end
        S_R_EXEC: begin
          c.alu_src_a = 1'b1;
          c.alu_src_b = SRCB_REG;
          c.alu_op    = r_op;
        end
        S_R_WB: begin
          c.reg_write  = 1'b1;
          c.reg_dst    = 1'b1;
          c.instr_done = 1'b1;
        end
        S_BRANCH: begin
          c.alu_src_a     = 1'b1;
          c.alu_src_b     = SRCB_REG;
          c.alu_op        = ALU_SUB;
          c.pc_write_cond = 1'b1;
          c.pc_source     = PCSRC_ALUOUT;
          c.instr_done    = 1'b1;
        end
        S_JUMP: begin
          c.pc_write   = 1'b1;
          c.pc_source  = PCSRC_JUMP;
          c.instr_done = 1'b1;
        end
        S_ADDI_WB: begin
          c.reg_write  = 1'b1;
          c.instr_done = 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign alu_op        = OP_WIDTH'(c.alu_op);
  assign alu_src_a     = c.alu_src_a;
  assign alu_src_b     = c.alu_src_b;
  assign iord          = c.iord;
  assign mem_read      = c.mem_read;
  assign mem_write     = c.mem_write;
  assign ir_write      = c.ir_write;
  assign pc_write      = c.pc_write;
  assign pc_write_cond = c.pc_write_cond;
  assign pc_source     = c.pc_source;
  assign reg_write     = c.reg_write;
  assign reg_dst       = c.reg_dst;
  assign mem_to_reg    = c.mem_to_reg;
  assign instr_done    = c.instr_done;
  assign illegal       = ill_q;
  assign state         = STATE_WIDTH'(cur);

`ifdef MIPS_MC_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cycle_count <= '0;
      instr_count <= '0;
    end else begin
      if (cur != S_ILLEGAL) cycle_count <= cycle_count + 32'd1;
      if (c.instr_done)     instr_count <= instr_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_mips_mc_control.sv
// Self-checking bench for mips_mc_control.
// Directed scenarios plus random instruction streams against a phase model.
module tb_mips_mc_control;

  logic       clk;
  logic       rst_n;
  logic [5:0] opcode;
  logic [5:0] funct;
  logic       mem_ready;
  logic [2:0] alu_op;
  logic       alu_src_a;
  logic [1:0] alu_src_b;
  logic       iord;
  logic       mem_read;
  logic       mem_write;
  logic       ir_write;
  logic       pc_write;
  logic       pc_write_cond;
  logic [1:0] pc_source;
  logic       reg_write;
  logic       reg_dst;
  logic       mem_to_reg;
  logic       instr_done;
  logic       illegal;
  logic [3:0] state;
`ifdef MIPS_MC_PERF_CNT_EN
  logic [31:0] cycle_count;
  logic [31:0] instr_count;
`endif

  int errors = 0;
  int checks = 0;

  mips_mc_control dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .opcode        (opcode),
    .funct         (funct),
    .mem_ready     (mem_ready),
    .alu_op        (alu_op),
    .alu_src_a     (alu_src_a),
    .alu_src_b     (alu_src_b),
    .iord          (iord),
    .mem_read      (mem_read),
    .mem_write     (mem_write),
    .ir_write      (ir_write),
    .pc_write      (pc_write),
    .pc_write_cond (pc_write_cond),
    .pc_source     (pc_source),
    .reg_write     (reg_write),
    .reg_dst       (reg_dst),
    .mem_to_reg    (mem_to_reg),
    .instr_done    (instr_done),
    .illegal       (illegal),
`ifdef MIPS_MC_PERF_CNT_EN
    .cycle_count   (cycle_count),
    .instr_count   (instr_count),
`endif
    .state         (state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // strobes: {mem_read, mem_write, ir_write, pc_write, pc_write_cond, reg_write, instr_done, illegal}
  // data:    {alu_op[2:0], alu_src_a, alu_src_b[1:0], iord, pc_source[1:0], reg_dst, mem_to_reg}
  logic [7:0]  obs_s;
  logic [10:0] obs_d;
  assign obs_s = {mem_read, mem_write, ir_write, pc_write,
                  pc_write_cond, reg_write, instr_done, illegal};
  assign obs_d = {alu_op, alu_src_a, alu_src_b, iord,
                  pc_source, reg_dst, mem_to_reg};

  typedef enum {
    P_FETCH, P_DECODE, P_ADDR, P_LOAD, P_LOADWB, P_STORE,
    P_REXEC, P_RWB, P_BEQ, P_J, P_IEXEC, P_IWB, P_ILL
  } ph_e;

  ph_e plan[$];

  // Returns {valid, op} for an R-type funct.
  function automatic logic [3:0] fn_op(input logic [5:0] fn);
    case (fn)
      6'h20:   return {1'b1, 3'b010};
      6'h22:   return {1'b1, 3'b011};
      6'h24:   return {1'b1, 3'b000};
      6'h25:   return {1'b1, 3'b001};
      6'h2A:   return {1'b1, 3'b100};
      default: return {1'b0, 3'b000};
    endcase
  endfunction

  function automatic void make_plan(input logic [5:0] op, input logic [5:0] fn);
    logic [3:0] f;
    f = fn_op(fn);
    plan = {};
    plan.push_back(P_FETCH);
    plan.push_back(P_DECODE);
    case (op)
      6'h00: begin
        plan.push_back(P_REXEC);
        if (f[3]) plan.push_back(P_RWB);
        else plan = {plan, P_ILL, P_ILL, P_ILL};
      end
      6'h23:   plan = {plan, P_ADDR, P_LOAD, P_LOADWB};
      6'h2B:   plan = {plan, P_ADDR, P_STORE};
      6'h04:   plan.push_back(P_BEQ);
      6'h02:   plan.push_back(P_J);
      6'h08:   plan = {plan, P_IEXEC, P_IWB};
      default: plan = {plan, P_ILL, P_ILL, P_ILL};
    endcase
  endfunction

  // Expected outputs for one cycle spent in phase p. Unlisted data fields are masked.
  function automatic void expect_for(input ph_e p, input bit rdy, input logic [5:0] fn,
                                     output logic [7:0] s, output logic [10:0] d,
                                     output logic [10:0] m);
    logic [3:0] f;
    f = fn_op(fn);
    s = '0;
    d = '0;
    m = '0;
    case (p)
      P_FETCH: begin
        s = {1'b1, 1'b0, rdy, rdy, 4'b0000};
        d = {3'b010, 1'b0, 2'b01, 1'b0, 2'b00, 2'b00};
        m = 11'b111_1_11_1_11_00;
      end
      P_DECODE: begin
        d = {3'b010, 1'b0, 2'b11, 5'b0};
        m = 11'b111_1_11_0_00_00;
      end
      P_ADDR, P_IEXEC: begin
        d = {3'b010, 1'b1, 2'b10, 5'b0};
        m = 11'b111_1_11_0_00_00;
      end
      P_LOAD: begin
        s = 8'b1000_0000;
        d = 11'b000_0_00_1_00_00;
        m = 11'b000_0_00_1_00_00;
      end
      P_LOADWB: begin
        s = 8'b0000_0110;
        d = 11'b000_0_00_0_00_01;
        m = 11'b000_0_00_0_00_11;
      end
      P_STORE: begin
        s = {1'b0, 1'b1, 4'b0000, rdy, 1'b0};
        d = 11'b000_0_00_1_00_00;
        m = 11'b000_0_00_1_00_00;
      end
      P_REXEC: begin
        d = {f[2:0], 1'b1, 2'b00, 5'b0};
        m = f[3] ? 11'b111_1_11_0_00_00 : 11'b000_1_11_0_00_00;
      end
      P_RWB: begin
        s = 8'b0000_0110;
        d = 11'b000_0_00_0_00_10;
        m = 11'b000_0_00_0_00_11;
      end
      P_BEQ: begin
        s = 8'b0000_1010;
        d = {3'b011, 1'b1, 2'b00, 1'b0, 2'b01, 2'b00};
        m = 11'b111_1_11_0_11_00;
      end
      P_J: begin
        s = 8'b0001_0010;
        d = 11'b000_0_00_0_10_00;
        m = 11'b000_0_00_0_11_00;
      end
      P_IWB: begin
        s = 8'b0000_0110;
        d = 11'b000_0_00_0_00_00;
        m = 11'b000_0_00_0_00_11;
      end
      P_ILL: s = 8'b0000_0001;
      default: ;
    endcase
  endfunction

  task automatic cyc(input bit rdy);
    @(posedge clk);
    #1;
    mem_ready = rdy;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
  endtask

  task automatic test_reset();
    rst_n     = 1'b0;
    mem_ready = 1'b1;
    opcode    = 6'h00;
    funct     = 6'h20;
    repeat (2) @(negedge clk);
    checks++;
    if (obs_s !== 8'h00) begin
      errors++;
      $display("FAIL reset_strobes got=%b want=00000000", obs_s);
    end
    checks++;
    if (obs_d !== 11'b010_0_00_0_00_00) begin
      errors++;
      $display("FAIL reset_data got=%b want=01000000000", obs_d);
    end
    mem_ready = 1'b0;
    rst_n     = 1'b1;
    cyc(1'b0);
    checks++;
    if ({mem_read, iord, ir_write, pc_write, illegal} !== 5'b10000) begin
      errors++;
      $display("FAIL reset_fetch got=%b want=10000",
               {mem_read, iord, ir_write, pc_write, illegal});
    end
  endtask

  task automatic test_add();
    int done_at;
    opcode  = 6'h00;
    funct   = 6'h20;
    done_at = -1;
    cyc(1'b1);
    checks++;
    if ({mem_read, ir_write, pc_write, alu_src_b} !== 5'b11101) begin
      errors++;
      $display("FAIL add_fetch got=%b want=11101",
               {mem_read, ir_write, pc_write, alu_src_b});
    end
    cyc(1'b1);
    checks++;
    if ({alu_src_a, alu_src_b, alu_op, obs_s} !== {1'b0, 2'b11, 3'b010, 8'h00}) begin
      errors++;
      $display("FAIL add_decode got=%b", {alu_src_a, alu_src_b, alu_op, obs_s});
    end
    cyc(1'b1);
    checks++;
    if ({alu_op, alu_src_a, alu_src_b, reg_write} !== 7'b010_1_00_0) begin
      errors++;
      $display("FAIL add_exec got=%b want=0101000",
               {alu_op, alu_src_a, alu_src_b, reg_write});
    end
    cyc(1'b1);
    if (instr_done) done_at = 4;
    checks++;
    if ({reg_write, reg_dst, mem_to_reg, done_at == 4} !== 4'b1101) begin
      errors++;
      $display("FAIL add_wb got=%b want=1101 done_at=%0d",
               {reg_write, reg_dst, mem_to_reg, instr_done}, done_at);
    end
  endtask

  task automatic test_lw();
    bit pat[7] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1};
    int nread;
    int ndone;
    int nstates;
    logic [3:0] prev;
    logic wb_ok;
    opcode  = 6'h23;
    funct   = 6'h00;
    nread   = 0;
    ndone   = 0;
    nstates = 0;
    prev    = 4'hF;
    wb_ok   = 1'b0;
    for (int i = 0; i < 7; i++) begin
      cyc(pat[i]);
      if (state !== prev) nstates++;
      prev = state;
      if (mem_read && iord) nread++;
      if (instr_done) begin
        ndone++;
        wb_ok = (i == 6) && reg_write && mem_to_reg && !reg_dst;
      end
    end
    checks++;
    if (nread !== 3) begin
      errors++;
      $display("FAIL lw_read_cycles got=%0d want=3", nread);
    end
    checks++;
    if (ndone !== 1 || wb_ok !== 1'b1 || nstates !== 5) begin
      errors++;
      $display("FAIL lw_wb done=%0d wb_ok=%b states=%0d want 1 1 5", ndone, wb_ok, nstates);
    end
  endtask

  task automatic test_sw();
    bit pat[5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b1};
    int nwrite;
    int nrw;
    int done_at;
    int both;
    opcode  = 6'h2B;
    nwrite  = 0;
    nrw     = 0;
    done_at = -1;
    both    = 0;
    for (int i = 0; i < 5; i++) begin
      cyc(pat[i]);
      if (mem_write) nwrite++;
      if (reg_write) nrw++;
      if (mem_read && mem_write) both++;
      if (instr_done) done_at = i;
    end
    checks++;
    if (nwrite !== 2 || nrw !== 0 || both !== 0) begin
      errors++;
      $display("FAIL sw_strobes mem_write=%0d reg_write=%0d both=%0d want 2 0 0",
               nwrite, nrw, both);
    end
    checks++;
    if (done_at !== 4) begin
      errors++;
      $display("FAIL sw_done got=%0d want=4", done_at);
    end
  endtask

  task automatic test_beq_j();
    opcode = 6'h04;
    repeat (3) cyc(1'b1);
    checks++;
    if ({alu_op, pc_write_cond, pc_source, instr_done, pc_write} !== 8'b011_1_01_1_0) begin
      errors++;
      $display("FAIL beq got=%b want=01110110",
               {alu_op, pc_write_cond, pc_source, instr_done, pc_write});
    end
    opcode = 6'h02;
    repeat (3) cyc(1'b1);
    checks++;
    if ({pc_write, pc_source, instr_done, pc_write_cond} !== 5'b1_10_1_0) begin
      errors++;
      $display("FAIL jump got=%b want=11010",
               {pc_write, pc_source, instr_done, pc_write_cond});
    end
  endtask

  task automatic test_reset_mid();
    opcode = 6'h23;
    repeat (3) cyc(1'b1);
    cyc(1'b0);
    @(posedge clk);
    #1;
    rst_n = 1'b0;
    #1;
    checks++;
    if (obs_s !== 8'h00 || alu_op !== 3'b010) begin
      errors++;
      $display("FAIL reset_mid_outputs strobes=%b alu_op=%b want 00000000 010", obs_s, alu_op);
    end
    @(negedge clk);
    rst_n = 1'b1;
    cyc(1'b0);
    checks++;
    if ({mem_read, iord, illegal, reg_write} !== 4'b1000) begin
      errors++;
      $display("FAIL reset_mid_fetch got=%b want=1000",
               {mem_read, iord, illegal, reg_write});
    end
  endtask

  task automatic test_illegal_funct();
    logic [3:0] frozen;
    int bad;
    opcode = 6'h00;
    funct  = 6'h27;
    cyc(1'b1);
    cyc(1'b1);
    cyc(1'b1);
    checks++;
    if (reg_write !== 1'b0 || illegal !== 1'b0) begin
      errors++;
      $display("FAIL nor_exec reg_write=%b illegal=%b want 0 0", reg_write, illegal);
    end
    cyc(1'b1);
    frozen = state;
    bad    = 0;
    for (int i = 0; i < 4; i++) begin
      cyc(i[0]);
      if (obs_s !== 8'b0000_0001 || state !== frozen) bad++;
    end
    checks++;
    if (bad !== 0) begin
      errors++;
      $display("FAIL nor_illegal_sticky bad_cycles=%0d strobes=%b want 0", bad, obs_s);
    end
    do_reset();
    checks++;
    if (illegal !== 1'b0) begin
      errors++;
      $display("FAIL illegal_clear got=%b want=0", illegal);
    end
  endtask

  task automatic test_random();
    logic [5:0] op;
    logic [5:0] fn;
    logic [5:0] ops[6] = '{6'h00, 6'h23, 6'h2B, 6'h04, 6'h02, 6'h08};
    logic [5:0] fns[5] = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    logic [7:0]  es;
    logic [10:0] ed;
    logic [10:0] em;
    int idx;
    int waits;
    bit rdy;
    bit mem_ph;
    for (int k = 0; k < 80; k++) begin
      op = ops[$urandom_range(0, 5)];
      fn = fns[$urandom_range(0, 4)];
      if ($urandom_range(0, 11) == 0) begin
        op = 6'(($urandom_range(0, 63)));
        if (op == 6'h00 || op == 6'h23 || op == 6'h2B || op == 6'h04 ||
            op == 6'h02 || op == 6'h08) op = 6'h3F;
      end else if (op == 6'h00 && $urandom_range(0, 9) == 0) begin
        fn = 6'h27;
      end
      make_plan(op, fn);
      idx   = 0;
      waits = 0;
      while (idx < plan.size()) begin
        mem_ph = (plan[idx] == P_FETCH) || (plan[idx] == P_LOAD) || (plan[idx] == P_STORE);
        rdy    = ($urandom_range(0, 2) != 0) || (waits >= 3);
        @(posedge clk);
        #1;
        opcode    = op;
        funct     = fn;
        mem_ready = rdy;
        @(negedge clk);
        expect_for(plan[idx], rdy, fn, es, ed, em);
        checks++;
        if (obs_s !== es || (obs_d & em) !== (ed & em)) begin
          errors++;
          $display("FAIL random k=%0d op=%h fn=%h phase=%s rdy=%b strobes=%b want=%b data=%b want=%b mask=%b",
                   k, op, fn, plan[idx].name(), rdy, obs_s, es, obs_d, ed, em);
        end
        if (mem_ph && !rdy) begin
          waits++;
        end else begin
          idx++;
          waits = 0;
        end
      end
      if (plan[plan.size()-1] == P_ILL) do_reset();
    end
  endtask

  initial begin
    rst_n     = 1'b0;
    mem_ready = 1'b0;
    opcode    = 6'h00;
    funct     = 6'h00;
    test_reset();
    test_add();
    test_lw();
    test_sw();
    test_beq_j();
    test_reset_mid();
    test_illegal_funct();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/mips_mc_control.md
Name: mips_mc_control

Overview:
- Multicycle MIPS main control FSM, directly upstream of the ALU.
- Sequences fetch/decode/execute/memory/writeback per instruction.
- Drives `alu_op` using the ALU encoding, plus operand-select, PC, IR, memory and register-file write controls for the shared datapath.
- Memory accesses use a `mem_ready` wait handshake.

Parameters:
- OP_WIDTH, 3, ALU op width (must match ALU).
- STATE_WIDTH, 4, FSM state register width.

Ports:
- clk  input  1  clock.
- rst_n  input  1  reset: asynchronous, active-low.
- opcode  input  6  instruction[31:26], from IR; valid from DECODE onward.
- funct  input  6  instruction[5:0], from IR.
- mem_ready  input  1  memory accepted/completed current access this cycle.
- alu_op  output  OP_WIDTH  000 and, 001 or, 010 add, 011 sub, 100 slt.
- alu_src_a  output  1  0=PC, 1=reg A.
- alu_src_b  output  2  00=reg B, 01=const 4, 10=sign-ext imm, 11=sign-ext imm<<2.
- iord  output  1  memory address: 0=PC, 1=ALU result.
- mem_read  output  1  memory read request.
- mem_write  output  1  memory write request.
- ir_write  output  1  load IR.
- pc_write  output  1  unconditional PC load.
- pc_write_cond  output  1  PC load if ALU zero.
- pc_source  output  2  00=ALU, 01=ALU result reg, 10=jump target.
- reg_write  output  1  register-file write.
- reg_dst  output  1  0=rt, 1=rd.
- mem_to_reg  output  1  0=ALU result, 1=memory data.
- instr_done  output  1  one-cycle pulse on the final cycle of each instruction.
- illegal  output  1  sticky: unsupported opcode/funct seen.
- state  output  STATE_WIDTH  current state, for debug.

Behaviour:
- Reset:
  - Async to FETCH; `illegal`=0.
  - While rst_n=0, every control output is forced 0 and `alu_op`=010.
  - Reset mid-instruction abandons it; no writes are issued.
- Outputs are a Moore decode of state. The exceptions are `ir_write`, `pc_write` in FETCH and `instr_done` on memory states, which are qualified by `mem_ready`.
- The ALU registers its result: the op driven in state S yields ALUOut in state S+1.
- FETCH:
  - Drives mem_read=1, iord=0, alu_src_a=0, alu_src_b=01, alu_op=add, pc_source=00.
  - Holds while mem_ready=0.
  - On mem_ready=1: ir_write=1, pc_write=1, then DECODE.
- DECODE:
  - Drives alu_src_a=0, alu_src_b=11, alu_op=add (branch target).
  - Branches on opcode:
    - 0x00 (R) -> R_EXEC.
    - 0x23 (lw) or 0x2B (sw) -> MEM_ADDR.
    - 0x04 (beq) -> BRANCH.
    - 0x02 (j) -> JUMP.
    - 0x08 (addi) -> ADDI_EXEC.
    - Any other opcode -> ILLEGAL.
- MEM_ADDR: alu_src_a=1, alu_src_b=10, add; then lw -> MEM_READ, sw -> MEM_WRITE.
- MEM_READ: mem_read=1, iord=1; holds until mem_ready, then MEM_WB.
- MEM_WB: reg_write=1, mem_to_reg=1, reg_dst=0; instr_done=1; then FETCH.
- MEM_WRITE: mem_write=1, iord=1; holds until mem_ready; instr_done=1 on the ready cycle; then FETCH.
- R_EXEC:
  - alu_src_a=1, alu_src_b=00.
  - funct 0x20 -> add, 0x22 -> sub, 0x24 -> and, 0x25 -> or, 0x2A -> slt.
  - Other funct -> ILLEGAL; no reg write occurs.
- R_WB: reg_write=1, reg_dst=1, mem_to_reg=0; instr_done; then FETCH.
- BRANCH: alu_src_a=1, alu_src_b=00, sub, pc_write_cond=1, pc_source=01; instr_done; then FETCH.
- JUMP: pc_write=1, pc_source=10; instr_done; then FETCH.
- ADDI_EXEC: alu_src_a=1, alu_src_b=10, add; then ADDI_WB.
- ADDI_WB: reg_write=1, reg_dst=0, mem_to_reg=0; instr_done; then FETCH.
- ILLEGAL: terminal; all writes 0; `illegal`=1 until reset.
- `mem_read` and `mem_write` are never both 1. All write strobes are 0 in any unlisted state.

Optional Feature:
- Macro MIPS_MC_PERF_CNT_EN.
- When defined, adds outputs `cycle_count[31:0]` and `instr_count[31:0]`.
  - `cycle_count` increments every cycle out of reset, except in ILLEGAL.
  - `instr_count` increments on `instr_done`.
  - Both reset to 0 and wrap at 2^32.
- When undefined, the ports and counters are absent; core behaviour is identical.

Decomposition:
- Package `mips_pkg`:
  - ALU op constants (AND/OR/ADD/SUB/SLT).
  - Opcode and funct constants.
  - State enum constants.
  - alu_src_b and pc_source encodings.
- Sub-module `mips_alu_decode`: combinational funct -> alu_op plus a funct-valid flag, reusable by a future pipelined decode.

Test Plan:
- add r3,r1,r2 (op 0x00, funct 0x20), mem_ready=1 always -> FETCH, DECODE, R_EXEC (alu_op=010), R_WB (reg_write=1, reg_dst=1); instr_done after 4 cycles.
- lw (0x23) with mem_ready low for 2 cycles in MEM_READ -> mem_read held 3 cycles with iord=1; then MEM_WB with mem_to_reg=1; 5 states total.
- sw (0x2B) -> mem_write=1 only in MEM_WRITE; reg_write never asserted; instr_done on the ready cycle.
- beq (0x04) -> BRANCH drives alu_op=011, pc_write_cond=1, pc_source=01; j (0x02) -> pc_write=1, pc_source=10.
- R-type funct 0x27 (nor) -> ILLEGAL after R_EXEC; illegal=1 sticky; no reg_write/mem_write; state frozen.
- rst_n low during MEM_READ -> outputs 0 immediately; after release, FETCH with mem_read=1 and illegal=0.
